// File: rtl/dp_pkg.sv
// Shared types for the dp64 accumulator slice.
// Precision modes, FSM states and per-mode sum widths.
package dp_pkg;

  typedef enum logic [1:0] {
    DP_INT2,
    DP_INT4,
    DP_INT8,
    DP_INT16
  } dp_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } dp_state_t;

  localparam int SUM_W_INT2  = 11;
  localparam int SUM_W_INT4  = 12;
  localparam int SUM_W_INT8  = 19;
  localparam int SUM_W_INT16 = 35;

endpackage

// File: rtl/dp_mode_mux.sv
// Picks the dp64 sum for the active precision.
// Result is zero-extended to the accumulator width.
import dp_pkg::*;

module dp_mode_mux #(
  parameter int ACC_W = 48
) (
  input  dp_mode_t                 i_mode,
  input  logic [SUM_W_INT2-1:0]    i_sum_int2,
  input  logic [SUM_W_INT4-1:0]    i_sum_int4,
  input  logic [SUM_W_INT8-1:0]    i_sum_int8,
  input  logic [SUM_W_INT16-1:0]   i_sum_int16,
  output logic [ACC_W-1:0]         o_operand
);

  // select one sum, the others are ignored
  always_comb begin
    o_operand = '0;
    unique case (i_mode)
      DP_INT2:  o_operand = ACC_W'(i_sum_int2);
      DP_INT4:  o_operand = ACC_W'(i_sum_int4);
      DP_INT8:  o_operand = ACC_W'(i_sum_int8);
      DP_INT16: o_operand = ACC_W'(i_sum_int16);
    endcase
  end

endmodule

// File: rtl/dp_accumulator.sv
// Multi-beat dot-product accumulator behind dp64.
// Saturating sum per vector, result held until taken.
import dp_pkg::*;

module dp_accumulator #(
  parameter int ACC_W     = 48,
  parameter int CNT_W     = 16,
  parameter int MAX_BEATS = 4096
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [1:0]             in_mode,
  input  logic [SUM_W_INT2-1:0]  sum_int2,
  input  logic [SUM_W_INT4-1:0]  sum_int4,
  input  logic [SUM_W_INT8-1:0]  sum_int8,
  input  logic [SUM_W_INT16-1:0] sum_int16,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_acc,
  output logic [1:0]             out_mode,
  output logic [CNT_W-1:0]       out_beats,
  output logic                   out_sat,
  output logic                   out_trunc
);

  dp_state_t        r_state;
  dp_mode_t         r_mode;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_beats;
  logic             r_sat;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_acc;
  logic [1:0]       r_out_mode;
  logic [CNT_W-1:0] r_out_beats;
  logic             r_out_sat;
  logic             r_out_trunc;

  dp_mode_t         w_sel_mode;
  logic [ACC_W-1:0] w_operand;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_sat_nxt;
  logic [CNT_W-1:0] w_beats_nxt;
  logic             w_take;
  logic             w_live;
  logic             w_close;

  // first beat uses the incoming mode, later beats the latched one
  assign w_sel_mode = in_first ? dp_mode_t'(in_mode) : r_mode;

  dp_mode_mux #(
    .ACC_W (ACC_W)
  ) u_mux (
    .i_mode      (w_sel_mode),
    .i_sum_int2  (sum_int2),
    .i_sum_int4  (sum_int4),
    .i_sum_int8  (sum_int8),
    .i_sum_int16 (sum_int16),
    .o_operand   (w_operand)
  );

  assign w_base      = in_first ? '0 : r_acc;
  assign {w_carry, w_sum} = {1'b0, w_base} + {1'b0, w_operand};
  assign w_acc_nxt   = w_carry ? '1 : w_sum;
  assign w_sat_nxt   = (in_first ? 1'b0 : r_sat) | w_carry;
  assign w_beats_nxt = in_first ? CNT_W'(1) : r_beats + CNT_W'(1);

  assign in_ready = (r_state != ST_HOLD);
  assign w_take   = in_valid & in_ready;
  assign w_live   = in_first | (r_state == ST_ACCUM);
  assign w_close  = w_take & w_live &
                    (in_last | (w_beats_nxt == CNT_W'(MAX_BEATS)));

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_mode  = r_out_mode;
  assign out_beats = r_out_beats;
  assign out_sat   = r_out_sat;
  assign out_trunc = r_out_trunc;

  // vector FSM, accumulator, counter and result registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_mode      <= DP_INT2;
      r_acc       <= '0;
      r_beats     <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_mode  <= 2'd0;
      r_out_beats <= '0;
      r_out_sat   <= 1'b0;
      r_out_trunc <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_take && w_live) begin
            r_acc   <= w_acc_nxt;
            r_sat   <= w_sat_nxt;
            r_beats <= w_beats_nxt;
            r_mode  <= w_sel_mode;
            if (w_close) begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
              r_out_acc   <= w_acc_nxt;
              r_out_mode  <= w_sel_mode;
              r_out_beats <= w_beats_nxt;
              r_out_sat   <= w_sat_nxt;
              r_out_trunc <= ~in_last;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
